// File: rtl/lsu_issue_queue.sv
// In-order load/store issue queue: circular FIFO feeding a one-request-at-a-time LSU handshake.
// Optional macro LSU_IQ_BYPASS_EN lets an enqueue into an empty idle queue issue directly.
module lsu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   enq_valid_i,
    output logic                   enq_ready_o,
    input  logic [XLEN-1:0]        enq_pc_i,
    input  logic [XLEN-1:0]        enq_inst_i,
    input  logic [XLEN-1:0]        enq_rs1_value_i,
    input  logic [XLEN-1:0]        enq_rs2_value_i,
    input  logic                   flush_i,
    input  logic                   lsu_busy_i,
    output logic                   lsu_request_o,
    output logic [XLEN-1:0]        pc_o,
    output logic [XLEN-1:0]        inst_o,
    output logic [XLEN-1:0]        rs1_value_o,
    output logic [XLEN-1:0]        rs2_value_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int PLW = 4 * XLEN;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PLW-1:0]  payload_q, payload_d;
    logic [PLW-1:0]  mem_q [DEPTH];

    logic [PLW-1:0]  enq_payload;
    logic            enq_fire;
    logic            enq_wr;
    logic            pop;
    logic            bypass;

    assign enq_payload = {enq_pc_i, enq_inst_i, enq_rs1_value_i, enq_rs2_value_i};
    // Readiness depends only on stored occupancy, never on a same-cycle pop.
    assign enq_ready_o = (count_q < DEPTH_C);
    assign enq_fire    = enq_valid_i && enq_ready_o && !flush_i;
    assign pop         = (state_q == IDLE) && (count_q != '0) && !lsu_busy_i && !flush_i;

`ifdef LSU_IQ_BYPASS_EN
    assign bypass = enq_fire && (state_q == IDLE) && (count_q == '0) && !lsu_busy_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry goes straight to the output registers and never occupies storage.
    assign enq_wr = enq_fire && !bypass;

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        payload_d = payload_q;
        if (flush_i) begin
            state_d = IDLE;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE:    if (pop || bypass) state_d = REQ;
                REQ:     state_d = HOLD;
                HOLD:    if (!lsu_busy_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if (enq_wr) tail_d = tail_q + PW'(1);
            if (pop)    head_d = head_q + PW'(1);
            count_d = count_q + CW'(enq_wr) - CW'(pop);
            if (pop)
                payload_d = mem_q[head_q];
            else if (bypass)
                payload_d = enq_payload;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            payload_q <= payload_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_wr) mem_q[tail_q] <= enq_payload;
    end

    assign lsu_request_o = (state_q == REQ);
    assign count_o       = count_q;
    assign pc_o          = payload_q[4*XLEN-1:3*XLEN];
    assign inst_o        = payload_q[3*XLEN-1:2*XLEN];
    assign rs1_value_o   = payload_q[2*XLEN-1:XLEN];
    assign rs2_value_o   = payload_q[XLEN-1:0];

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Directed bench for lsu_issue_queue (default build, DEPTH=4, XLEN=32).
module tb_lsu_issue_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk_i = 1'b0;
    logic            reset_ni;
    logic            enq_valid_i;
    logic            enq_ready_o;
    logic [XLEN-1:0] enq_pc_i, enq_inst_i, enq_rs1_value_i, enq_rs2_value_i;
    logic            flush_i;
    logic            lsu_busy_i;
    logic            lsu_request_o;
    logic [XLEN-1:0] pc_o, inst_o, rs1_value_o, rs2_value_o;
    logic [2:0]      count_o;

    int checks   = 0;
    int failures = 0;

    lsu_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i           (clk_i),
        .reset_ni        (reset_ni),
        .enq_valid_i     (enq_valid_i),
        .enq_ready_o     (enq_ready_o),
        .enq_pc_i        (enq_pc_i),
        .enq_inst_i      (enq_inst_i),
        .enq_rs1_value_i (enq_rs1_value_i),
        .enq_rs2_value_i (enq_rs2_value_i),
        .flush_i         (flush_i),
        .lsu_busy_i      (lsu_busy_i),
        .lsu_request_o   (lsu_request_o),
        .pc_o            (pc_o),
        .inst_o          (inst_o),
        .rs1_value_o     (rs1_value_o),
        .rs2_value_o     (rs2_value_o),
        .count_o         (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_enq(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst,
                           input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2);
        enq_valid_i     = 1'b1;
        enq_pc_i        = pc;
        enq_inst_i      = inst;
        enq_rs1_value_i = rs1;
        enq_rs2_value_i = rs2;
    endtask

    initial begin
        logic [XLEN-1:0] exp_q [$];
        int n_req;
        int sent;
        int rcvd;
        int max_cnt;
        logic rdy;

        reset_ni = 1'b0;
        enq_valid_i = 1'b0;
        enq_pc_i = '0; enq_inst_i = '0; enq_rs1_value_i = '0; enq_rs2_value_i = '0;
        flush_i = 1'b0;
        lsu_busy_i = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ready", enq_ready_o, 1);
        check("rst_count", count_o, 0);
        check("rst_req", lsu_request_o, 0);
        check("rst_inst", inst_o, 0);
        check("rst_pc", pc_o, 0);
        reset_ni = 1'b1;
        tick();
        check("post_rst_ready", enq_ready_o, 1);

        // Single store: request two cycles after the enqueue cycle, one cycle wide
        set_enq(32'h100, 32'h0020A223, 32'h0, 32'hFFFF);
        tick();
        enq_valid_i = 1'b0;
        check("t1_count_after_enq", count_o, 1);
        check("t1_no_req_yet", lsu_request_o, 0);
        tick();
        check("t1_req", lsu_request_o, 1);
        check("t1_inst", inst_o, 32'h0020A223);
        check("t1_rs2", rs2_value_o, 32'hFFFF);
        check("t1_rs1", rs1_value_o, 32'h0);
        check("t1_pc", pc_o, 32'h100);
        check("t1_count_popped", count_o, 0);
        tick();
        check("t1_req_one_cycle", lsu_request_o, 0);
        check("t1_inst_held", inst_o, 32'h0020A223);
        tick();
        check("t1_idle_no_req", lsu_request_o, 0);

        // Back-to-back SW then LB, busy stalls the second issue
        set_enq(32'h200, 32'h0020A223, 32'h10, 32'h20);
        tick();
        set_enq(32'h204, 32'h00400183, 32'h30, 32'h40);
        tick();
        enq_valid_i = 1'b0;
        check("t2_req_sw", lsu_request_o, 1);
        check("t2_inst_sw", inst_o, 32'h0020A223);
        check("t2_count_enq_and_pop", count_o, 1);
        lsu_busy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_busy_no_req", lsu_request_o, 0);
            check("t2_busy_inst_held", inst_o, 32'h0020A223);
        end
        lsu_busy_i = 1'b0;
        tick();
        check("t2_hold_exit_no_req", lsu_request_o, 0);
        tick();
        check("t2_req_lb", lsu_request_o, 1);
        check("t2_inst_lb", inst_o, 32'h00400183);
        check("t2_pc_lb", pc_o, 32'h204);
        check("t2_count_empty", count_o, 0);
        tick();
        tick();

        // Fill while busy: 5th enqueue dropped, then exactly 4 ordered requests
        lsu_busy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_enq(32'h300 + i, 32'h11 + i, 32'h0, 32'h0);
            check("t3_ready_before_enq", enq_ready_o, (i < 4) ? 1 : 0);
            tick();
        end
        enq_valid_i = 1'b0;
        check("t3_count_full", count_o, 4);
        check("t3_ready_full", enq_ready_o, 0);
        check("t3_no_req_while_busy", lsu_request_o, 0);
        lsu_busy_i = 1'b0;
        n_req = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (lsu_request_o) begin
                if (n_req < 4) check("t3_order", inst_o, 32'h11 + n_req);
                n_req++;
            end
        end
        check("t3_num_requests", n_req, 4);
        check("t3_count_drained", count_o, 0);

        // Flush with 3 queued entries, enqueue in the flush cycle is dropped
        lsu_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_enq(32'h400 + i, 32'h21 + i, 32'h0, 32'h0);
            tick();
        end
        check("t4_count_3", count_o, 3);
        set_enq(32'h4FF, 32'h2F, 32'h0, 32'h0);
        lsu_busy_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        enq_valid_i = 1'b0;
        check("t4_count_flushed", count_o, 0);
        check("t4_ready_flushed", enq_ready_o, 1);
        check("t4_no_req_flush_edge", lsu_request_o, 0);
        n_req = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (lsu_request_o) n_req++;
        end
        check("t4_no_req_after_flush", n_req, 0);

        // 3*DEPTH entries 0x1..0xC streamed through, pointers wrap
        sent = 0;
        rcvd = 0;
        max_cnt = 0;
        for (int c = 0; c < 200 && rcvd < 12; c++) begin
            if (sent < 12) set_enq(sent + 1, sent + 1, 32'h0, 32'h0);
            else enq_valid_i = 1'b0;
            rdy = enq_ready_o;
            tick();
            if (enq_valid_i && rdy) sent++;
            if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
            if (lsu_request_o) begin
                check("t5_order_inst", inst_o, rcvd + 1);
                check("t5_order_pc", pc_o, rcvd + 1);
                rcvd++;
            end
        end
        enq_valid_i = 1'b0;
        check("t5_received", rcvd, 12);
        check("t5_sent", sent, 12);
        check("t5_reached_full", max_cnt, DEPTH);
        tick();
        tick();
        tick();

        // Async reset while in HOLD with 2 entries queued
        set_enq(32'h501, 32'h31, 32'h0, 32'h0);
        tick();
        set_enq(32'h502, 32'h32, 32'h0, 32'h0);
        tick();
        check("t6_req_first", lsu_request_o, 1);
        set_enq(32'h503, 32'h33, 32'h0, 32'h0);
        tick();
        enq_valid_i = 1'b0;
        lsu_busy_i = 1'b1;
        tick();
        check("t6_count_2", count_o, 2);
        check("t6_inst_before_rst", inst_o, 32'h31);
        #2;
        reset_ni = 1'b0;
        #1;
        check("t6_rst_req", lsu_request_o, 0);
        check("t6_rst_inst", inst_o, 0);
        check("t6_rst_pc", pc_o, 0);
        check("t6_rst_rs2", rs2_value_o, 0);
        check("t6_rst_count", count_o, 0);
        check("t6_rst_ready", enq_ready_o, 1);
        tick();
        reset_ni = 1'b1;
        lsu_busy_i = 1'b0;
        n_req = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (lsu_request_o) n_req++;
        end
        check("t6_issue_abandoned", n_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_issue_queue.md
LSU_ISSUE_QUEUE -- requirements
Module: lsu_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, power of two >= 2; entry count.
REQ-002 Parameter XLEN, default 32; width of pc/inst/operand fields.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 reset_ni  input  1  asynchronous, active-low reset.
REQ-005 enq_valid_i  input  1  dispatch offers one load/store.
REQ-006 enq_ready_o  output  1  queue accepts; high iff count_o < DEPTH.
REQ-007 enq_pc_i / enq_inst_i / enq_rs1_value_i / enq_rs2_value_i  input  XLEN each  entry payload.
REQ-008 flush_i  input  1  discard all queued entries.
REQ-009 lsu_busy_i  input  1  downstream LSU busy.
REQ-010 lsu_request_o  output  1  one-cycle issue pulse to LSU.
REQ-011 pc_o / inst_o / rs1_value_o / rs2_value_o  output  XLEN each  registered payload of the issued entry.
REQ-012 count_o  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-013 Storage SHALL be a circular FIFO with head/tail pointers wrapping modulo DEPTH; order is strictly preserved.
REQ-014 Enqueue SHALL occur on an edge where enq_valid_i && enq_ready_o && !flush_i; enq_ready_o ignores a same-cycle pop.
REQ-015 Enqueue attempts while full SHALL be dropped with no state change.
REQ-016 FSM states SHALL be IDLE, REQ, HOLD.
REQ-017 IDLE -> REQ when count_o > 0 && !lsu_busy_i && !flush_i; on that edge the head entry is loaded into output registers and popped.
REQ-018 lsu_request_o SHALL be high exactly while in REQ (one cycle); REQ -> HOLD unconditionally.
REQ-019 HOLD -> IDLE when lsu_busy_i == 0; otherwise stay; minimum spacing between request pulses is 3 cycles.
REQ-020 Payload outputs SHALL hold the last issued entry until the next issue.
REQ-021 Simultaneous enqueue and pop SHALL leave count_o unchanged and both take effect.
REQ-022 flush_i SHALL, on the next edge, clear pointers and count_o to 0 and force IDLE; a request already high in the flush cycle is not retracted; enqueue in the flush cycle is dropped.
REQ-023 count_o SHALL never exceed DEPTH nor underflow.

Reset
REQ-024 On reset_ni low, asynchronously: FSM = IDLE, pointers = 0, count_o = 0, lsu_request_o = 0, all payload outputs = 0.
REQ-025 enq_ready_o SHALL be 1 during and after reset; reset mid-issue abandons the issue.
REQ-026 Entry storage need not be reset.

Configuration
REQ-027 Macro LSU_IQ_BYPASS_EN: when defined, an enqueue in IDLE with count_o == 0 and !lsu_busy_i SHALL load the output registers directly and enter REQ on the same edge (request visible the next cycle), without occupying an entry.
REQ-028 Without LSU_IQ_BYPASS_EN, every entry SHALL pass through storage; empty-queue enqueue-to-request latency is 2 cycles.

Verification
REQ-029 Reset, then enqueue SW inst 0x0020A223, rs1 0x0, rs2 0xFFFF, busy 0 -> lsu_request_o pulses 1 cycle, 2 cycles after enqueue edge (1 with bypass), inst_o = 0x0020A223, rs2_value_o = 0xFFFF.
REQ-030 Enqueue SW 0x0020A223 then LB 0x00400183 back-to-back, busy high 4 cycles after first request -> second request only after busy drops, inst_o = 0x00400183, order preserved.
REQ-031 Busy held 1, enqueue 5 entries with DEPTH=4 -> enq_ready_o = 0 after 4th, 5th dropped, count_o = 4; release busy -> exactly 4 requests in order.
REQ-032 3 entries queued, assert flush_i 1 cycle -> count_o = 0 next cycle, no further lsu_request_o.
REQ-033 Fill and drain 3*DEPTH entries with payloads 0x1..0xC -> pointers wrap, outputs arrive 0x1..0xC in order.
REQ-034 Drop reset_ni while in HOLD with 2 entries -> all outputs 0 immediately, count_o = 0, enq_ready_o = 1.
